id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage that directly feeds the ALU.
- Registers decoded operands and control from ID, then drives ALU inputs A, B and ALUOp through EX-side forwarding muxes.
- Handles stall (hold), flush (bubble insertion) and load-use detection.
- Keeps a saturating bubble counter for debug.

Parameters:
- DW, 32, datapath width (A, B, immediates, results)
- RW, 5, register-index width
- OPW, 3, ALUOp width
- CNT_W, 16, bubble-counter width

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  RW  source/destination indices
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  extended immediate
- id_alusrc  in  1  1: B = immediate
- id_aluop  in  OPW  ALU operation
- id_regwrite, id_memread, id_memwrite  in  1  control bits
- stall  in  1  hold stage contents
- flush  in  1  replace next contents with bubble
- exmem_regwrite  in  1  EX/MEM writes a register
- exmem_rd  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM result
- memwb_regwrite  in  1  MEM/WB writes a register
- memwb_rd  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB writeback value
- A, B  out  DW  ALU operands (signed interpretation is the ALU's)
- ALUOp  out  OPW  ALU operation
- ex_valid  out  1  EX holds a real instruction
- ex_rd  out  RW  destination
- ex_regwrite, ex_memread, ex_memwrite  out  1  registered control bits
- ex_store_data  out  DW  forwarded rt value for stores
- load_use  out  1  load-use hazard request to the hazard unit
- bubble_cnt  out  CNT_W  number of bubbles inserted

Behaviour:
- Reset (rstn=0, asynchronous): all stage registers clear to 0.
  - ex_valid, control bits, ex_rd and ALUOp are 0; bubble_cnt is 0.
  - A, B and ex_store_data are therefore 0.
- Normal capture: on each rising edge with stall=0 and flush=0, all id_* values load into the stage registers. Latency is one cycle from ID to ALU inputs.
- Stall: with stall=1 and flush=0, all stage registers hold their values. bubble_cnt is unchanged.
- Flush: with flush=1, the stage loads a bubble and bubble_cnt increments.
  - Bubble: ex_valid=0, ex_regwrite=0, ex_memread=0, ex_memwrite=0, ex_rd=0, ALUOp=ALUOP_NOP.
  - Flush overrides stall.
  - id_valid=0 on a normal capture also loads a bubble, but does not increment bubble_cnt.
- bubble_cnt saturates at all-ones and never wraps.
- Forwarding is combinational from the registered rs/rt values and applies to each of rs and rt.
  - If exmem_regwrite and exmem_rd != 0 and exmem_rd == reg index: use exmem_result.
  - Else if memwb_regwrite and memwb_rd != 0 and memwb_rd == reg index: use memwb_result.
  - Else: use the registered data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - A = forwarded rs.
  - B = registered alusrc ? registered imm : forwarded rt.
  - ex_store_data = forwarded rt, regardless of alusrc.
- Forwarding is active even when ex_valid=0 (harmless, because a bubble's control bits are 0).
- load_use is combinational and asserts when all hold:
  - ex_valid and ex_memread;
  - ex_rd != 0;
  - id_valid;
  - id_rs == ex_rd or id_rt == ex_rd.
- This block never self-stalls: the hazard unit is expected to drive stall to ID/IF and flush to this stage in response to load_use.
- Reset mid-stall or mid-flush: reset wins immediately.

Decomposition:
- Shared package cpu_pkg holds:
  - ALUOp encodings, including ALUOP_NOP = 3'b000 (ADD);
  - default widths DW, RW, OPW;
  - REG_ZERO = 0.
- One natural sub-module: fwd_mux, which resolves one operand. It is instantiated twice, for rs and rt.

Test Plan:
- Reset then capture: id_rs_data=2, id_rt_data=13, alusrc=0, aluop=3'b001, id_valid=1 -> one cycle later A=2, B=13, ALUOp=001, ex_valid=1.
- Immediate select: alusrc=1, id_imm=32'hFFFF_FFF0, id_rt_data=7 -> B=32'hFFFF_FFF0, ex_store_data=7.
- Forward priority:
  - Registered rs=5; exmem_rd=5, exmem_result=100; memwb_rd=5, memwb_result=200, both regwrite=1 -> A=100.
  - Drop exmem_regwrite -> A=200.
  - rs=0 with matching rd=0 -> A=registered data.
- Stall/flush:
  - Hold stall=1 for 3 cycles while changing id_* -> outputs unchanged.
  - Assert stall=1 and flush=1 together -> bubble (ex_valid=0, ALUOp=000), bubble_cnt 0->1.
- Load-use: a load with ex_rd=8 in EX, and ID with id_rt=8, id_valid=1 -> load_use=1.
  - ex_rd=0 -> load_use=0.
  - ex_memread=0 -> load_use=0.
- Counter saturation and async reset:
  - With CNT_W=2, flush 5 times -> bubble_cnt=3.
  - Pulse rstn low between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, ALU operation encodings
// and the hardwired-zero register index.
package cpu_pkg;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int OPW = 3;

  localparam int REG_ZERO = 0;

  typedef enum logic [2:0] {
    ALUOP_ADD = 3'b000,
    ALUOP_SUB = 3'b001,
    ALUOP_AND = 3'b010,
    ALUOP_OR  = 3'b011,
    ALUOP_XOR = 3'b100,
    ALUOP_SLT = 3'b101,
    ALUOP_SLL = 3'b110,
    ALUOP_SRL = 3'b111
  } aluop_e;

  // A bubble executes as an ADD whose result is never written back.
  localparam logic [2:0] ALUOP_NOP = ALUOP_ADD;

endpackage

// File: rtl/fwd_mux.sv
// Resolves one EX operand from the pipeline-register value or a younger result
// still in flight in EX/MEM or MEM/WB. EX/MEM is the most recent and wins.
module fwd_mux #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] fwd_data
);
  import cpu_pkg::*;

  logic exmem_hit;
  logic memwb_hit;

  // Register zero reads as a constant, so a pending write to it is never forwarded.
  assign exmem_hit = exmem_regwrite && (exmem_rd != RW'(REG_ZERO)) && (exmem_rd == idx);
  assign memwb_hit = memwb_regwrite && (memwb_rd != RW'(REG_ZERO)) && (memwb_rd == idx);

  always_comb begin
    fwd_data = reg_data;
    if (exmem_hit) begin
      fwd_data = exmem_result;
    end else if (memwb_hit) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: stall/flush handling, operand
// forwarding, load-use detection and a saturating bubble counter.
module id_ex_stage #(
  parameter int DW    = cpu_pkg::DW,
  parameter int RW    = cpu_pkg::RW,
  parameter int OPW   = cpu_pkg::OPW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic             id_alusrc,
  input  logic [OPW-1:0]   id_aluop,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             stall,
  input  logic             flush,
  input  logic             exmem_regwrite,
  input  logic [RW-1:0]    exmem_rd,
  input  logic [DW-1:0]    exmem_result,
  input  logic             memwb_regwrite,
  input  logic [RW-1:0]    memwb_rd,
  input  logic [DW-1:0]    memwb_result,
  output logic [DW-1:0]    A,
  output logic [DW-1:0]    B,
  output logic [OPW-1:0]   ALUOp,
  output logic             ex_valid,
  output logic [RW-1:0]    ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [DW-1:0]    ex_store_data,
  output logic             load_use,
  output logic [CNT_W-1:0] bubble_cnt
);
  import cpu_pkg::*;

  logic             valid_reg;
  logic [RW-1:0]    rs_reg, rt_reg, rd_reg;
  logic [DW-1:0]    rs_data_reg, rt_data_reg, imm_reg;
  logic             alusrc_reg;
  logic [OPW-1:0]   aluop_reg;
  logic             regwrite_reg, memread_reg, memwrite_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [DW-1:0]    rs_fwd, rt_fwd;
  logic             load_bubble;

  // A flush, or an empty ID slot on a normal capture, loads an all-zero bubble.
  assign load_bubble = flush || !id_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg    <= 1'b0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      rd_reg       <= '0;
      rs_data_reg  <= '0;
      rt_data_reg  <= '0;
      imm_reg      <= '0;
      alusrc_reg   <= 1'b0;
      aluop_reg    <= '0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      cnt_reg      <= '0;
    end else if (flush || !stall) begin
      valid_reg    <= load_bubble ? 1'b0 : 1'b1;
      rs_reg       <= load_bubble ? '0 : id_rs;
      rt_reg       <= load_bubble ? '0 : id_rt;
      rd_reg       <= load_bubble ? '0 : id_rd;
      rs_data_reg  <= load_bubble ? '0 : id_rs_data;
      rt_data_reg  <= load_bubble ? '0 : id_rt_data;
      imm_reg      <= load_bubble ? '0 : id_imm;
      alusrc_reg   <= load_bubble ? 1'b0 : id_alusrc;
      aluop_reg    <= load_bubble ? OPW'(ALUOP_NOP) : id_aluop;
      regwrite_reg <= load_bubble ? 1'b0 : id_regwrite;
      memread_reg  <= load_bubble ? 1'b0 : id_memread;
      memwrite_reg <= load_bubble ? 1'b0 : id_memwrite;
      if (flush && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx            (rs_reg),
    .reg_data       (rs_data_reg),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .fwd_data       (rs_fwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx            (rt_reg),
    .reg_data       (rt_data_reg),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .fwd_data       (rt_fwd)
  );

  assign A             = rs_fwd;
  assign B             = alusrc_reg ? imm_reg : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign ALUOp         = aluop_reg;
  assign ex_valid      = valid_reg;
  assign ex_rd         = rd_reg;
  assign ex_regwrite   = regwrite_reg;
  assign ex_memread    = memread_reg;
  assign ex_memwrite   = memwrite_reg;
  assign bubble_cnt    = cnt_reg;

  assign load_use = valid_reg && memread_reg && (rd_reg != RW'(REG_ZERO)) && id_valid &&
                    ((id_rs == rd_reg) || (id_rt == rd_reg));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the stage.
module tb_id_ex_stage;

  logic        clk;
  logic        rstn;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc;
  logic [2:0]  id_aluop;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        stall, flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;

  logic [31:0] A, B, ex_store_data;
  logic [2:0]  ALUOp;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use;
  logic [4:0]  ex_rd;
  logic [15:0] bubble_cnt;

  logic [31:0] s_A, s_B, s_store;
  logic [2:0]  s_aluop;
  logic        s_valid, s_regwrite, s_memread, s_memwrite, s_load_use;
  logic [4:0]  s_rd;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  // Reference state: what the stage is supposed to be holding.
  typedef struct {
    bit          valid;
    bit [4:0]    rs, rt, rd;
    bit [31:0]   rs_data, rt_data, imm;
    bit          alusrc;
    bit [2:0]    aluop;
    bit          regwrite, memread, memwrite;
  } slot_t;

  slot_t m;
  int    m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .stall(stall), .flush(flush), .exmem_regwrite(exmem_regwrite),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .A(A), .B(B), .ALUOp(ALUOp),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data), .load_use(load_use),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .stall(stall), .flush(flush), .exmem_regwrite(exmem_regwrite),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .A(s_A), .B(s_B), .ALUOp(s_aluop),
    .ex_valid(s_valid), .ex_rd(s_rd), .ex_regwrite(s_regwrite), .ex_memread(s_memread),
    .ex_memwrite(s_memwrite), .ex_store_data(s_store), .load_use(s_load_use),
    .bubble_cnt(s_cnt)
  );

  function automatic slot_t empty_slot();
    slot_t e;
    e.valid = 0; e.rs = 0; e.rt = 0; e.rd = 0; e.rs_data = 0; e.rt_data = 0; e.imm = 0;
    e.alusrc = 0; e.aluop = 3'b000; e.regwrite = 0; e.memread = 0; e.memwrite = 0;
    return e;
  endfunction

  function automatic void model_reset();
    m = empty_slot();
    m_cnt = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    if (flush) begin
      m = empty_slot();
      m_cnt = m_cnt + 1;
    end else if (!stall) begin
      if (id_valid) begin
        m.valid = 1; m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
        m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
        m.alusrc = id_alusrc; m.aluop = id_aluop;
        m.regwrite = id_regwrite; m.memread = id_memread; m.memwrite = id_memwrite;
      end else begin
        m = empty_slot();
      end
    end
  endfunction

  function automatic bit [31:0] fwd(input bit [4:0] idx, input bit [31:0] data);
    if (idx == 0) return data;
    if (exmem_regwrite && exmem_rd == idx) return exmem_result;
    if (memwb_regwrite && memwb_rd == idx) return memwb_result;
    return data;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string ctx);
    bit exp_lu;
    bit [31:0] exp_rt;
    #2;
    exp_lu = m.valid && m.memread && (m.rd != 0) && id_valid && (id_rs == m.rd || id_rt == m.rd);
    exp_rt = fwd(m.rt, m.rt_data);
    chk({ctx, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
    chk({ctx, ".ALUOp"}, 32'(ALUOp), 32'(m.aluop));
    chk({ctx, ".ex_rd"}, 32'(ex_rd), 32'(m.rd));
    chk({ctx, ".ctrl"}, {29'd0, ex_regwrite, ex_memread, ex_memwrite},
        {29'd0, m.regwrite, m.memread, m.memwrite});
    chk({ctx, ".load_use"}, 32'(load_use), 32'(exp_lu));
    chk({ctx, ".bubble_cnt"}, 32'(bubble_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    chk({ctx, ".bubble_cnt_sat"}, 32'(s_cnt), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    if (m.valid) begin
      chk({ctx, ".A"}, A, fwd(m.rs, m.rs_data));
      chk({ctx, ".B"}, B, m.alusrc ? m.imm : exp_rt);
      chk({ctx, ".store"}, ex_store_data, exp_rt);
    end
    $display("txn %-10s valid=%0d A=%h B=%h op=%0d rd=%0d lu=%0d cnt=%0d", ctx, ex_valid, A, B,
             ALUOp, ex_rd, load_use, bubble_cnt);
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                        input bit src, input bit [2:0] op, input bit rw, input bit mr, input bit mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alusrc = src; id_aluop = op;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  initial begin
    rstn = 1'b0; stall = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    model_reset();
    #1;
    check_all("reset");
    chk("reset.A", A, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    set_id(1, 1, 2, 3, 2, 13, 0, 0, 3'b001, 1, 0, 0);
    tick(); check_all("capture");
    chk("capture.A", A, 32'd2);
    chk("capture.B", B, 32'd13);
    chk("capture.op", 32'(ALUOp), 32'd1);

    set_id(1, 1, 2, 3, 2, 7, 32'hFFFF_FFF0, 1, 3'b000, 1, 0, 0);
    tick(); check_all("imm");
    chk("imm.B", B, 32'hFFFF_FFF0);
    chk("imm.store", ex_store_data, 32'd7);

    set_id(1, 5, 6, 4, 32'h11, 32'h22, 0, 0, 3'b010, 1, 0, 0);
    tick();
    exmem_regwrite = 1; exmem_rd = 5; exmem_result = 100;
    memwb_regwrite = 1; memwb_rd = 5; memwb_result = 200;
    check_all("fwd_exmem");
    chk("fwd_exmem.A", A, 32'd100);
    exmem_regwrite = 0;
    check_all("fwd_memwb");
    chk("fwd_memwb.A", A, 32'd200);

    set_id(1, 0, 6, 4, 32'h55, 32'h22, 0, 0, 3'b010, 1, 0, 0);
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
    tick(); check_all("fwd_r0");
    chk("fwd_r0.A", A, 32'h55);
    exmem_regwrite = 0; memwb_regwrite = 0;

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'(i + 9), 5'(i + 10), 5'(i + 11), $urandom, $urandom, $urandom, 1, 3'b111, 0, 1, 1);
      tick(); check_all("stall");
    end
    chk("stall.A", A, 32'h55);

    flush = 1;
    tick(); check_all("flush");
    chk("flush.cnt", 32'(bubble_cnt), 32'd1);
    flush = 0; stall = 0;

    set_id(1, 1, 2, 8, 0, 0, 0, 1, 3'b000, 1, 1, 0);
    tick();
    set_id(1, 3, 8, 4, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    check_all("lu_hit");
    chk("lu_hit.load_use", 32'(load_use), 32'd1);

    set_id(1, 1, 2, 0, 0, 0, 0, 1, 3'b000, 0, 1, 0);
    tick();
    set_id(1, 0, 0, 4, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    check_all("lu_rd0");
    chk("lu_rd0.load_use", 32'(load_use), 32'd0);

    set_id(1, 1, 2, 8, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    tick();
    set_id(1, 3, 8, 4, 0, 0, 0, 0, 3'b000, 1, 0, 0);
    check_all("lu_noload");
    chk("lu_noload.load_use", 32'(load_use), 32'd0);

    flush = 1;
    for (int i = 0; i < 5; i++) begin
      tick(); check_all("sat");
    end
    chk("sat.cnt2", 32'(s_cnt), 32'd3);
    chk("sat.cnt16", 32'(bubble_cnt), 32'd6);
    flush = 0;

    for (int i = 0; i < 300; i++) begin
      set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom),
             3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
      tick(); check_all("rand");
      if (i % 97 == 50) begin
        rstn = 1'b0;
        model_reset();
        check_all("rand_rst");
        rstn = 1'b1;
      end
    end

    set_id(1, 2, 3, 4, 32'hAA, 32'hBB, 0, 0, 3'b011, 1, 1, 0);
    stall = 0; flush = 0;
    tick();
    stall = 1; flush = 1;
    rstn = 1'b0;
    model_reset();
    check_all("async_rst");
    chk("async_rst.A", A, 32'd0);
    chk("async_rst.B", B, 32'd0);
    rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
